div32_seq: RTL and testbench



---
 rtl/div_pkg.sv | 14 +
 rtl/div32_seq_if.sv | 25 ++
 rtl/div_step.sv | 23 ++
 rtl/div32_seq.sv | 97 +++++++++
 tb/tb_div32_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div32_seq_if.sv
// Start/busy/done handshake and operand/result bundle for div32_seq.
interface div32_seq_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and keep the difference only when it did not borrow.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r_next,
  output logic [WIDTH-1:0] o_q_next
);
  logic [WIDTH:0] w_rs;
  logic [WIDTH:0] w_t;
  logic           w_unused;

  // The partial remainder never exceeds the divisor, so its top bit is always zero.
  assign w_unused = i_r[WIDTH];

  assign w_rs     = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_t      = w_rs - {1'b0, i_d};
  assign o_r_next = w_t[WIDTH] ? w_rs : w_t;
  assign o_q_next = {i_q[WIDTH-2:0], ~w_t[WIDTH]};
endmodule

// File: rtl/div32_seq.sv
// Multicycle unsigned divider: one quotient bit per clock, divide-by-zero short-circuits
// straight to the done cycle.
module div32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic        clk,
  input logic        reset,
  div32_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_r      (r_rem),
    .i_q      (r_q),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_next (w_q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // start is deliberately ignored here; operands stay as captured.
          r_rem <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(WIDTH - 1)) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_remd  <= w_r_next[WIDTH-1:0];
            r_dbz   <= 1'b0;
          end
        end
        default: begin
          // IDLE and FIN both accept a new request, giving back-to-back operation.
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remd  <= bus.dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_rem   <= '0;
              r_q     <= bus.dividend;
              r_d     <= bus.divisor;
              r_cnt   <= '0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div32_seq.sv
// Directed-vector bench for div32_seq: table of hand-computed results plus handshake
// corner sequences and a short random sweep against the / and % operators.
module tb_div32_seq;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div32_seq_if #(.WIDTH(32)) bus ();

  div32_seq #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the current point until done is seen; busy must hold meanwhile.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      check({name, " busy in run"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy at done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    launch(a, b);
    wait_done(name, (b == 32'd0) ? 0 : 32);
    check({name, " quotient"}, bus.quotient, eq);
    check({name, " remainder"}, bus.remainder, er);
    check({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0};
    vecs[2]  = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,    1'b0};
    vecs[3]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1};
    vecs[4]  = '{32'd9,          32'd3,          32'd3,          32'd0,    1'b0};
    vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0};
    vecs[6]  = '{32'd7,          32'd10,         32'd0,          32'd7,    1'b0};
    vecs[7]  = '{32'd81,         32'd9,          32'd9,          32'd0,    1'b0};
    vecs[8]  = '{32'd50,         32'd8,          32'd6,          32'd2,    1'b0};
    vecs[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0};
    vecs[10] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,    1'b0};
    vecs[11] = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,    1'b0};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // start held high for part of RUN with other operands must not disturb the division.
    launch(32'd100, 32'd7);
    bus.start    = 1'b1;
    bus.dividend = 32'd1;
    bus.divisor  = 32'd1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    wait_done("start during busy", 27);
    check("start during busy quotient", bus.quotient, 32'd14);
    check("start during busy remainder", bus.remainder, 32'd2);
    @(posedge clk);
    #1;

    // Back-to-back: new request issued in the FIN cycle of the previous one.
    launch(32'd100, 32'd7);
    wait_done("b2b first", 32);
    check("b2b first quotient", bus.quotient, 32'd14);
    launch(32'd81, 32'd9);
    check("b2b held quotient", bus.quotient, 32'd14);
    check("b2b held remainder", bus.remainder, 32'd2);
    wait_done("b2b second", 32);
    check("b2b second quotient", bus.quotient, 32'd9);
    check("b2b second remainder", bus.remainder, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN, coinciding with a start request.
    launch(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort quotient", bus.quotient, 32'd0);
    check("abort remainder", bus.remainder, 32'd0);
    check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    check("abort no activity", done_seen, 0);
    run_div("after abort", 32'd50, 32'd8, 32'd6, 32'd2, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(16, 1));
      if (i % 10 == 3) ra = 32'd0;
      if (i % 7 == 5) ra = 32'($urandom_range(1000, 0));
      if (rb == 32'd0) rb = 32'd1;
      run_div($sformatf("rand%0d", i), ra, rb, ra / rb, ra % rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
